// File: rtl/tx_prbs_source.sv
// PRBS7 symbol source for the TX path: emits +/-AMPLITUDE levels with
// fixed-point start times over a valid/ready handshake, halting on timestamp overflow.
module tx_prbs_source #(
  parameter int unsigned TIME_WIDTH      = 32,
  parameter int unsigned TIME_UI         = 1000,
  parameter int unsigned FILTER_IN_WIDTH = 16,
  parameter int unsigned AMPLITUDE       = 16384,
  parameter logic [6:0]  PRBS_SEED       = 7'h01
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [TIME_WIDTH-1:0]             out_time,
  output logic signed [FILTER_IN_WIDTH-1:0] out_value,
  output logic                              out_bit,
  output logic [31:0]                       sym_count,
  output logic                              time_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [TIME_WIDTH:0] UI_EXT = (TIME_WIDTH + 1)'(TIME_UI);
  localparam logic signed [FILTER_IN_WIDTH-1:0] AMP_POS = FILTER_IN_WIDTH'(AMPLITUDE);
  localparam logic signed [FILTER_IN_WIDTH-1:0] AMP_NEG = -AMP_POS;

  state_t                              state_q, state_d;
  logic [6:0]                          lfsr_q, lfsr_d;
  logic [TIME_WIDTH-1:0]               time_q, time_d;
  logic [31:0]                         count_q, count_d;
  logic                                ovf_q, ovf_d;
  logic signed [FILTER_IN_WIDTH-1:0]   value_q, value_d;
  logic [TIME_WIDTH:0]                 time_sum;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    time_d   = time_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    time_sum = {1'b0, time_q} + UI_EXT;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        // The accepted symbol always consumes a PRBS bit and a count, even when
        // the timestamp can no longer advance and the source halts.
        if (out_ready) begin
          count_d = count_q + 32'd1;
          lfsr_d  = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
          if (time_sum[TIME_WIDTH]) begin
            ovf_d   = 1'b1;
            state_d = HALT;
          end else begin
            time_d = time_sum[TIME_WIDTH-1:0];
            if (!en) state_d = IDLE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: state_d = IDLE;
    endcase
    value_d = lfsr_d[6] ? AMP_POS : AMP_NEG;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= PRBS_SEED;
      time_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      value_q <= PRBS_SEED[6] ? AMP_POS : AMP_NEG;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      time_q  <= time_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      value_q <= value_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign out_time  = time_q;
  assign out_value = value_q;
  assign out_bit   = lfsr_q[6];
  assign sym_count = count_q;
  assign time_ovf  = ovf_q;

endmodule
